muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer attached to the execute stage. It accepts MULT/MULTU/DIV/DIVU operations issued from EX and iterates one bit per cycle into private HI/LO registers. It raises `stall` only when the pipeline issues a new mul/div or reads HI/LO while an operation is still in flight. Ordinary ALU instructions keep flowing through execute in parallel.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_paso.sv | 40 ++++
 rtl/muldiv_ctrl.sv | 130 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the multiply/divide sequencer
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // Bit 1 of the op selects divide; bit 0 clear means signed operands.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_paso.sv
// rtl/muldiv_paso.sv - one combinational shift-add / restoring-divide iteration
module muldiv_paso
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_acc,
  input  logic [WIDTH-1:0]     i_oper,
  output logic [2*WIDTH-1:0]   o_acc
);

  // Multiply: upper half plus multiplicand when the multiplier LSB is set,
  // carry kept so the right shift does not lose it.
  logic [WIDTH:0] w_sum;
  // Divide: partial remainder shifted left with the next dividend bit.
  logic [WIDTH:0] w_part;
  // Low WIDTH bits of the trial subtract plus its borrow.
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_oper} : '0);
  assign w_part  = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
  assign w_trial = {1'b0, w_part[WIDTH-1:0]} - {1'b0, i_oper};
  // The divisor fits if the shifted-out top bit is set or the low subtract has no borrow.
  assign w_fits  = w_part[WIDTH] | ~w_trial[WIDTH];

  // Select the next accumulator value for the current operation.
  always_comb begin
    o_acc = '0;
    if (!i_is_div) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else if (w_fits) begin
      o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operando_1,
  input  logic [WIDTH-1:0] operando_2,
  input  logic             lee_hilo,
  input  logic             kill,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_cero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_oper;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_cero;

  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_1;
  logic [WIDTH-1:0]   w_abs_2;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div_zero;

  assign w_signed = op_is_signed(op);
  assign w_abs_1  = (w_signed & operando_1[WIDTH-1]) ? -operando_1 : operando_1;
  assign w_abs_2  = (w_signed & operando_2[WIDTH-1]) ? -operando_2 : operando_2;

  muldiv_paso #(.WIDTH(WIDTH)) u_paso (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_oper   (r_oper),
    .o_acc    (w_acc_next)
  );

  // Sign fix-up of the magnitude result. With a zero divisor the quotient is
  // left as all ones, and negating the remainder (= |dividend|) restores the
  // dividend exactly as it was sampled.
  assign w_div_zero = (r_oper == '0);
  assign w_prod     = r_neg_q ? -r_acc : r_acc;
  assign w_quo      = (r_neg_q & ~w_div_zero) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Sequencer: latch operands, iterate WIDTH times, then correct signs and write HI/LO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_oper     <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_cero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_cero <= 1'b0;
      if (kill) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_is_div <= op_is_div(op);
              r_neg_q  <= w_signed & (operando_1[WIDTH-1] ^ operando_2[WIDTH-1]);
              r_neg_r  <= w_signed & operando_1[WIDTH-1];
              r_acc    <= {{WIDTH{1'b0}}, (op_is_div(op) ? w_abs_1 : w_abs_2)};
              r_oper   <= op_is_div(op) ? w_abs_2 : w_abs_1;
              r_cnt    <= CW'(WIDTH - 1);
              r_state  <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_acc <= w_acc_next;
            if (r_cnt == '0) begin
              r_state <= ST_FIX;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_FIX: begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b1;
            r_div_cero <= r_is_div & w_div_zero;
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign stall    = busy & (start | lee_hilo);
  assign done     = r_done;
  assign div_cero = r_div_cero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operando_1 = '0;
  logic [31:0] operando_2 = '0;
  logic        lee_hilo = 1'b0;
  logic        kill = 1'b0;
  logic        busy, stall, done, div_cero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .operando_1 (operando_1),
    .operando_2 (operando_2),
    .lee_hilo   (lee_hilo),
    .kill       (kill),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .div_cero   (div_cero),
    .hi         (hi),
    .lo         (lo)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = sa * sb; {eh, el} = p; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {eh, el} = up; end
      default: begin
        if (b == 32'd0) begin
          ez = 1'b1; el = 32'hFFFFFFFF; eh = a;
        end else if (o == 2'b11) begin
          el = a / b; eh = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          el = 32'h80000000; eh = 32'd0;
        end else begin
          el = 32'(sa / sb); eh = 32'(sa % sb);
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from idle and check latency, busy span and results.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] eh, el;
    logic        ez;
    int          e, nb;
    model(o, a, b, eh, el, ez);
    @(negedge clock);
    op = o; operando_1 = a; operando_2 = b; start = 1'b1;
    #1 chk({tag, " stall_idle"}, stall, 0);
    e = 0; nb = 0;
    do begin
      @(negedge clock);
      e++;
      start = 1'b0;
      if (busy) nb++;
    end while (!done && e < 100);
    chk({tag, " latency"}, 64'(e - 1), 64'd33);
    chk({tag, " busy_cycles"}, 64'(nb), 64'd33);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    chk({tag, " div_cero"}, div_cero, ez);
    @(negedge clock);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " div_cero_pulse"}, div_cero, 0);
  endtask

  task automatic wait_done(output int e);
    e = 0;
    while (!done && e < 100) begin
      @(negedge clock);
      e++;
    end
  endtask

  initial begin
    int e, nb, ns;
    logic seen;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst div_cero", div_cero, 0);
    reset_n = 1'b1;

    // Directed operations
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, "mult_neg");
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, "div_neg");
    run_op(2'b11, 32'd5, 32'd0, "divu_zero");
    run_op(2'b10, 32'hFFFFFFF7, 32'd0, "div_zero_neg");
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(2'b00, 32'h80000000, 32'h80000000, "mult_minmin");

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op(o, a, b, "rand");
    end

    // Back-to-back: DIVU held behind an in-flight MULTU
    @(negedge clock);
    op = 2'b01; operando_1 = 32'd2; operando_2 = 32'd3; start = 1'b1;
    @(negedge clock);
    op = 2'b11; operando_1 = 32'd7; operando_2 = 32'd2;
    e = 0; nb = 0; ns = 0;
    while (!done && e < 100) begin
      if (busy) begin
        nb++;
        if (stall) ns++;
      end
      @(negedge clock);
      e++;
    end
    chk("b2b busy_cycles", 64'(nb), 64'd33);
    chk("b2b stall_cycles", 64'(ns), 64'd33);
    chk("b2b first lo", lo, 32'd6);
    chk("b2b first hi", hi, 32'd0);
    chk("b2b done_stall", stall, 0);
    lee_hilo = 1'b1;
    #1 chk("b2b done_read_stall", stall, 0);
    lee_hilo = 1'b0;
    @(negedge clock);
    chk("b2b accepted", busy, 1);
    lee_hilo = 1'b1;
    #1 chk("lee_hilo busy stall", stall, 1);
    lee_hilo = 1'b0;
    start = 1'b0;
    #1 chk("quiet busy stall", stall, 0);
    wait_done(e);
    chk("b2b second done", done, 1);
    chk("b2b second lo", lo, 32'd3);
    chk("b2b second hi", hi, 32'd1);
    @(negedge clock);
    lee_hilo = 1'b1;
    #1 chk("lee_hilo idle stall", stall, 0);
    lee_hilo = 1'b0;

    // kill has priority over start in idle
    @(negedge clock);
    op = 2'b01; operando_1 = 32'd2; operando_2 = 32'd3; start = 1'b1; kill = 1'b1;
    @(negedge clock);
    chk("kill_vs_start busy", busy, 0);
    start = 1'b0; kill = 1'b0;

    // kill mid-operation leaves HI/LO untouched
    run_op(2'b11, 32'd55, 32'd7, "prep_kill");
    @(negedge clock);
    op = 2'b01; operando_1 = 32'hFFFFFFFF; operando_2 = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("kill pre busy", busy, 1);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    chk("kill busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    chk("kill no_done", seen, 0);
    chk("kill hi", hi, 32'd6);
    chk("kill lo", lo, 32'd7);

    // Asynchronous reset mid-operation
    run_op(2'b11, 32'd55, 32'd7, "prep_rst");
    @(negedge clock);
    op = 2'b00; operando_1 = 32'd123; operando_2 = 32'd456; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("rst pre busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst hi", hi, 0);
    chk("async rst lo", lo, 0);
    chk("async rst done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    chk("async rst no_done", seen, 0);
    run_op(2'b10, 32'd100, 32'hFFFFFFF9, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
